// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one single-port 4096x8 RAM between the CPU (port 0) and the boot/debug loader (port 1).
// Fixed port 0 priority; define RAM_ARB_STARVE_GUARD_EN to bound port 1's wait to MAX_WAIT cycles.
module ram_arbiter #(
  parameter int MAX_WAIT = 4
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [11:0] m0_addr,
  input  logic [7:0]  m0_wdata,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  output logic [7:0]  m0_rdata,

  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [11:0] m1_addr,
  input  logic [7:0]  m1_wdata,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic [7:0]  m1_rdata,

  output logic [11:0] ram_addr,
  output logic [7:0]  ram_data_in,
  output logic        ram_we,
  input  logic [7:0]  ram_data_out
);

  typedef struct packed {
    logic        we;
    logic [11:0] addr;
    logic [7:0]  wdata;
  } acc_t;

  typedef enum logic {
    OWNER_M0 = 1'b0,
    OWNER_M1 = 1'b1
  } owner_t;

  if (MAX_WAIT < 1 || MAX_WAIT > 15) begin : g_bad_max_wait
    $error("ram_arbiter: MAX_WAIT must be in 1..15");
  end

  acc_t   acc0;
  acc_t   acc1;
  acc_t   sel;
  logic   any_gnt;
  logic   m1_starved;
  owner_t rd_owner;
  logic   rd_pending;

  assign acc0 = '{we: m0_we, addr: m0_addr, wdata: m0_wdata};
  assign acc1 = '{we: m1_we, addr: m1_addr, wdata: m1_wdata};

`ifdef RAM_ARB_STARVE_GUARD_EN
  // Counts consecutive refused cycles of port 1; saturates so a stuck requester cannot wrap.
  logic [3:0] wait_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if (m1_req && !m1_gnt) begin
      if (wait_cnt != 4'd15) begin
        wait_cnt <= wait_cnt + 4'd1;
      end
    end else begin
      wait_cnt <= '0;
    end
  end

  assign m1_starved = (wait_cnt >= 4'(MAX_WAIT));
`else
  assign m1_starved = 1'b0;
`endif

  always_comb begin
    m0_gnt = 1'b0;
    m1_gnt = 1'b0;
    if (!reset) begin
      if (m1_req && (!m0_req || m1_starved)) begin
        m1_gnt = 1'b1;
      end else if (m0_req) begin
        m0_gnt = 1'b1;
      end
    end
  end

  assign any_gnt = m0_gnt | m1_gnt;

  // Idle cycles present port 0's fields with we low: the RAM does a read nobody consumes.
  assign sel         = m1_gnt ? acc1 : acc0;
  assign ram_addr    = sel.addr;
  assign ram_data_in = sel.wdata;
  assign ram_we      = any_gnt & sel.we;

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_pending <= 1'b0;
      rd_owner   <= OWNER_M0;
    end else begin
      rd_pending <= any_gnt & ~sel.we;
      if (any_gnt) begin
        rd_owner <= m1_gnt ? OWNER_M1 : OWNER_M0;
      end
    end
  end

  // Gating with reset drops a read that was granted just before reset asserted.
  assign m0_rvalid = rd_pending & ~reset & (rd_owner == OWNER_M0);
  assign m1_rvalid = rd_pending & ~reset & (rd_owner == OWNER_M1);
  assign m0_rdata  = ram_data_out;
  assign m1_rdata  = ram_data_out;

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: behavioural RAM plus a transaction-level reference model.
module tb_ram_arbiter;
  localparam int MAX_WAIT = 4;
`ifdef RAM_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_req, m0_we, m0_gnt, m0_rvalid;
  logic [11:0] m0_addr;
  logic [7:0]  m0_wdata, m0_rdata;
  logic        m1_req, m1_we, m1_gnt, m1_rvalid;
  logic [11:0] m1_addr;
  logic [7:0]  m1_wdata, m1_rdata;
  logic [11:0] ram_addr;
  logic [7:0]  ram_data_in, ram_data_out;
  logic        ram_we;

  always #5 clk = ~clk;

  ram_arbiter #(.MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .ram_addr(ram_addr), .ram_data_in(ram_data_in), .ram_we(ram_we),
    .ram_data_out(ram_data_out)
  );

  logic [7:0] ram [4096];
  always @(posedge clk) begin
    if (ram_we) ram[ram_addr] <= ram_data_in;
    ram_data_out <= ram[ram_addr];
  end

  // Reference model: memory image, pending read, and how long port 1 has been refused.
  logic [7:0]  ref_mem [4096];
  int          waited;
  int          rd_port;
  logic [7:0]  rd_val;
  logic        exp_g0, exp_g1, exp_we, exp_rv0, exp_rv1;
  logic [11:0] exp_addr;
  logic [7:0]  exp_wd;
  int          checks;
  int          errors;

  task automatic predict();
    @(negedge clk);
    exp_g1  = !reset && m1_req && (!m0_req || (GUARD && waited >= MAX_WAIT));
    exp_g0  = !reset && m0_req && !exp_g1;
    exp_rv0 = !reset && rd_port == 0;
    exp_rv1 = !reset && rd_port == 1;
    if (exp_g1) begin
      exp_addr = m1_addr; exp_wd = m1_wdata; exp_we = m1_we;
    end else begin
      exp_addr = m0_addr; exp_wd = m0_wdata; exp_we = exp_g0 && m0_we;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    rd_port = -1;
    if (reset) begin
      waited = 0;
    end else begin
      if (exp_g0 || exp_g1) begin
        if (exp_we) ref_mem[exp_addr] = exp_wd;
        else begin
          rd_port = exp_g1 ? 1 : 0;
          rd_val  = ref_mem[exp_addr];
        end
      end
      if (m1_req && !exp_g1) waited = (waited < 15) ? waited + 1 : 15;
      else waited = 0;
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 12'hFFF; m0_wdata = 8'hA5;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 12'h000; m1_wdata = 8'h00;
    for (int i = 0; i < 3; i++) begin
      predict();
      checks++;
      if (ram_we !== 1'b0) begin errors++; $display("FAIL reset_ram_we cyc%0d: got %b want 0", i, ram_we); end
      checks++;
      if ({m0_gnt, m1_gnt} !== 2'b00) begin errors++; $display("FAIL reset_gnt cyc%0d: got %b want 00", i, {m0_gnt, m1_gnt}); end
      checks++;
      if ({m0_rvalid, m1_rvalid} !== 2'b00) begin errors++; $display("FAIL reset_rvalid cyc%0d: got %b want 00", i, {m0_rvalid, m1_rvalid}); end
      tick();
    end
    reset = 1'b0;
    predict();
    checks++;
    if ({m0_gnt, m1_gnt} !== 2'b10) begin errors++; $display("FAIL reset_first_gnt: got %b want 10", {m0_gnt, m1_gnt}); end
    tick();
    m0_req = 1'b0; m1_req = 1'b0;
    predict();
    tick();
  endtask

  task automatic test_p0_write_read();
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 12'h123; m0_wdata = 8'h5A;
    predict();
    checks++;
    if ({m0_gnt, ram_we, ram_addr, ram_data_in} !== {1'b1, 1'b1, 12'h123, 8'h5A}) begin
      errors++; $display("FAIL p0_write: got gnt=%b we=%b addr=%h din=%h want 1 1 123 5a", m0_gnt, ram_we, ram_addr, ram_data_in);
    end
    tick();
    m0_we = 1'b0;
    predict();
    checks++;
    if ({m0_gnt, ram_we, m0_rvalid} !== 3'b100) begin
      errors++; $display("FAIL p0_read_gnt: got gnt=%b we=%b rvalid=%b want 1 0 0", m0_gnt, ram_we, m0_rvalid);
    end
    tick();
    m0_req = 1'b0;
    predict();
    checks++;
    if ({m0_rvalid, m1_rvalid, m0_rdata} !== {2'b10, 8'h5A}) begin
      errors++; $display("FAIL p0_read_data: got rv0=%b rv1=%b rdata=%h want 1 0 5a", m0_rvalid, m1_rvalid, m0_rdata);
    end
    tick();
  endtask

  task automatic test_p1_only();
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 12'h000;
    predict();
    checks++;
    if ({m0_gnt, m1_gnt} !== 2'b01) begin errors++; $display("FAIL p1_gnt: got %b want 01", {m0_gnt, m1_gnt}); end
    tick();
    m1_req = 1'b0;
    predict();
    checks++;
    if ({m0_rvalid, m1_rvalid, m1_rdata} !== {2'b01, 8'h10}) begin
      errors++; $display("FAIL p1_read_data: got rv0=%b rv1=%b rdata=%h want 0 1 10", m0_rvalid, m1_rvalid, m1_rdata);
    end
    tick();
  endtask

  task automatic test_contention();
    logic want1;
    m0_req = 1'b1; m0_we = 1'b0; m1_req = 1'b1; m1_we = 1'b0;
    m1_addr = 12'($urandom_range(0, 4095));
    for (int i = 0; i < 20; i++) begin
      m0_addr = 12'($urandom_range(0, 4095));
      predict();
      want1 = GUARD && (i % 5 == 4);
      checks++;
      if ({m0_gnt, m1_gnt} !== {!want1, want1}) begin
        errors++; $display("FAIL contention_gnt cyc%0d: got %b want %b", i, {m0_gnt, m1_gnt}, {!want1, want1});
      end
      checks++;
      if ({m0_rvalid, m1_rvalid} !== {exp_rv0, exp_rv1}) begin
        errors++; $display("FAIL contention_rvalid cyc%0d: got %b want %b", i, {m0_rvalid, m1_rvalid}, {exp_rv0, exp_rv1});
      end
      if (exp_rv0 || exp_rv1) begin
        checks++;
        if (m0_rdata !== rd_val) begin errors++; $display("FAIL contention_rdata cyc%0d: got %h want %h", i, m0_rdata, rd_val); end
      end
      tick();
      if (want1) m1_addr = 12'($urandom_range(0, 4095));
    end
    m0_req = 1'b0; m1_req = 1'b0;
    predict();
    tick();
  endtask

  task automatic test_reset_mid_read();
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 12'h123;
    predict();
    checks++;
    if (m0_gnt !== 1'b1) begin errors++; $display("FAIL midread_gnt: got %b want 1", m0_gnt); end
    tick();
    m0_req = 1'b0; reset = 1'b1;
    predict();
    checks++;
    if ({m0_rvalid, m1_rvalid} !== 2'b00) begin errors++; $display("FAIL midread_rvalid: got %b want 00", {m0_rvalid, m1_rvalid}); end
    tick();
    reset = 1'b0;
    predict();
    checks++;
    if ({m0_rvalid, m1_rvalid} !== 2'b00) begin errors++; $display("FAIL midread_after: got %b want 00", {m0_rvalid, m1_rvalid}); end
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      if (!m0_req || exp_g0) begin
        m0_req = ($urandom_range(0, 3) != 0); m0_we = 1'($urandom);
        m0_addr = 12'($urandom_range(0, 15)); m0_wdata = 8'($urandom);
      end
      if (!m1_req || exp_g1) begin
        m1_req = ($urandom_range(0, 3) != 0); m1_we = 1'($urandom);
        m1_addr = 12'($urandom_range(0, 15)); m1_wdata = 8'($urandom);
      end
      reset = ($urandom_range(0, 63) == 0);
      predict();
      checks++;
      if ({m0_gnt, m1_gnt, ram_we} !== {exp_g0, exp_g1, exp_we}) begin
        errors++; $display("FAIL rand_gnt cyc%0d: got g0g1we=%b want %b", i, {m0_gnt, m1_gnt, ram_we}, {exp_g0, exp_g1, exp_we});
      end
      checks++;
      if (ram_addr !== exp_addr || (exp_we && ram_data_in !== exp_wd)) begin
        errors++; $display("FAIL rand_ram_drive cyc%0d: got addr=%h din=%h want %h %h", i, ram_addr, ram_data_in, exp_addr, exp_wd);
      end
      checks++;
      if ({m0_rvalid, m1_rvalid} !== {exp_rv0, exp_rv1}) begin
        errors++; $display("FAIL rand_rvalid cyc%0d: got %b want %b", i, {m0_rvalid, m1_rvalid}, {exp_rv0, exp_rv1});
      end
      if (exp_rv0 || exp_rv1) begin
        checks++;
        if ((exp_rv0 ? m0_rdata : m1_rdata) !== rd_val) begin
          errors++; $display("FAIL rand_rdata cyc%0d: got %h want %h", i, exp_rv0 ? m0_rdata : m1_rdata, rd_val);
        end
      end
      tick();
      // A reset cycle ends with no grant, so fields stay held as the protocol requires.
    end
    reset = 1'b0; m0_req = 1'b0; m1_req = 1'b0;
    predict();
    tick();
  endtask

  initial begin
    checks = 0; errors = 0; waited = 0; rd_port = -1; rd_val = 8'h00;
    exp_g0 = 1'b0; exp_g1 = 1'b0;
    for (int i = 0; i < 4096; i++) begin
      ram[i]     = 8'((i * 37 + 16) & 255);
      ref_mem[i] = 8'((i * 37 + 16) & 255);
    end
    test_reset();
    test_p0_write_read();
    test_p1_only();
    test_contention();
    test_reset_mid_read();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
